// File: rtl/serial_frame_rx_if.sv
// Serial receiver bus: bit stream and strobe in, parallel word handshake and error flags out.
interface serial_frame_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             Din;
    logic             En;
    logic             Ready;
    logic             ClrErr;
    logic [WIDTH-1:0] Data;
    logic             Valid;
    logic             FrameErr;
    logic             ParErr;
    logic             Overrun;

    modport master (
        output Din, En, Ready, ClrErr,
        input  Data, Valid, FrameErr, ParErr, Overrun
    );

    modport slave (
        input  Din, En, Ready, ClrErr,
        output Data, Valid, FrameErr, ParErr, Overrun
    );
endinterface

// File: rtl/serial_frame_rx.sv
// UART-style frame receiver sampling Din on En strobes; delivers words on a valid/ready handshake.
// Optional even-parity bit compiled in with SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    serial_frame_rx_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;
`endif

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic             perr_q, perr_d;
    logic             par_bad, par_bad_d;
`endif

    // Next-state and next-output logic; only En-qualified cycles advance the frame.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shreg_d = shreg;
        data_d  = data_q;
        valid_d = valid_q & ~bus.Ready;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q & ~bus.ClrErr;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad;
`endif
        if (bus.En) begin
            case (state)
                IDLE: begin
                    if (!bus.Din) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = (shreg >> 1) | (WIDTH'(bus.Din) << (WIDTH - 1));
                    cnt_d   = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                PARITY: begin
                    par_bad_d = bus.Din ^ (^shreg);
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    state_d = IDLE;
                    if (!bus.Din) begin
                        ferr_d = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_d = 1'b1;
`endif
                    end else if (!valid_q || bus.Ready) begin
                        data_d  = shreg;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            perr_q  <= 1'b0;
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            shreg   <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            perr_q  <= perr_d;
            par_bad <= par_bad_d;
`endif
        end
    end

    assign bus.Data     = data_q;
    assign bus.Valid    = valid_q;
    assign bus.FrameErr = ferr_q;
    assign bus.Overrun  = ovr_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign bus.ParErr   = perr_q;
`else
    assign bus.ParErr   = 1'b0;
`endif
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: queue-based frame model checked every cycle plus directed literal checks.
module tb_serial_frame_rx;
    localparam int unsigned W = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int unsigned FLEN = W + 3;
`else
    localparam int unsigned FLEN = W + 2;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_frame_rx_if #(.WIDTH(W)) bus ();
    serial_frame_rx #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: collect sampled bits of a frame, judge the whole frame once complete.
    logic         mq[$];
    logic [W-1:0] m_data, word;
    logic         m_valid, m_ferr, m_perr, m_ovr, was_valid, par_ok, ovr_set;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
            m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
        end else begin
            was_valid = m_valid;
            m_valid   = m_valid && !bus.Ready;
            m_ferr    = 1'b0;
            m_perr    = 1'b0;
            ovr_set   = 1'b0;
            if (bus.En) begin
                if (mq.size() != 0 || bus.Din == 1'b0) mq.push_back(bus.Din);
                if (mq.size() == FLEN) begin
                    for (int i = 0; i < W; i++) word[i] = mq[1 + i];
                    par_ok = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    par_ok = ((^word) == mq[W + 1]);
`endif
                    if (!mq[FLEN - 1]) m_ferr = 1'b1;
                    else if (!par_ok) m_perr = 1'b1;
                    else if (!was_valid || bus.Ready) begin
                        m_data  = word;
                        m_valid = 1'b1;
                    end else ovr_set = 1'b1;
                    mq.delete();
                end
            end
            m_ovr = (m_ovr && !bus.ClrErr) || ovr_set;
        end
    end

    always @(negedge CLK) begin
        chk("model_data", 32'(bus.Data), 32'(m_data));
        chk("model_valid", 32'(bus.Valid), 32'(m_valid));
        chk("model_frameerr", 32'(bus.FrameErr), 32'(m_ferr));
        chk("model_parerr", 32'(bus.ParErr), 32'(m_perr));
        chk("model_overrun", 32'(bus.Overrun), 32'(m_ovr));
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.En = 1'b0; bus.Din = 1'b1;
            @(posedge CLK); #1;
        end
    endtask

    task automatic send_bit(input logic d, input logic gap);
        bus.Din = d; bus.En = 1'b1;
        @(posedge CLK); #1;
        bus.En = 1'b0;
        if (gap) begin
            bus.Din = ~d;
            @(posedge CLK); #1;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic par_flip, input logic stop,
                              input logic gap, input logic rdy_stop, input logic clr_stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) send_bit(w[i], gap);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_bit((^w) ^ par_flip, gap);
`endif
        bus.Din = stop; bus.En = 1'b1; bus.Ready = rdy_stop; bus.ClrErr = clr_stop;
        @(posedge CLK); #1;
        bus.En = 1'b0; bus.Din = 1'b1; bus.Ready = 1'b0; bus.ClrErr = 1'b0;
    endtask

    task automatic accept();
        bus.Ready = 1'b1;
        @(posedge CLK); #1;
        bus.Ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        bus.Din = 1'b1; bus.En = 1'b0; bus.Ready = 1'b0; bus.ClrErr = 1'b0;
        #7;
        chk("rst_data", 32'(bus.Data), 32'h0);
        chk("rst_valid", 32'(bus.Valid), 32'h0);
        chk("rst_flags", 32'({bus.FrameErr, bus.ParErr, bus.Overrun}), 32'h0);
        @(posedge CLK); #1 RST = 1'b0;
        idle(2);

        // Basic frame, then hold while Ready low
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("basic_data", 32'(bus.Data), 32'hA5);
        chk("basic_valid", 32'(bus.Valid), 32'h1);
        chk("basic_ferr", 32'(bus.FrameErr), 32'h0);
        idle(3);
        chk("basic_hold", 32'({bus.Valid, bus.Data}), 32'h1A5);
        accept();
        chk("basic_accept", 32'(bus.Valid), 32'h0);

        // Strobe gaps
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("gap_data", 32'({bus.Valid, bus.Data}), 32'h1A5);
        accept();

        // Framing error and recovery
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ferr_pulse", 32'(bus.FrameErr), 32'h1);
        chk("ferr_novalid", 32'(bus.Valid), 32'h0);
        idle(1);
        chk("ferr_oneshot", 32'(bus.FrameErr), 32'h0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("recover_data", 32'({bus.Valid, bus.Data}), 32'h13C);
        accept();

        // Overrun
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovr_data", 32'({bus.Valid, bus.Data}), 32'h101);
        chk("ovr_set", 32'(bus.Overrun), 32'h1);
        accept();
        chk("ovr_accept", 32'({bus.Valid, bus.Overrun}), 32'h1);
        bus.ClrErr = 1'b1;
        @(posedge CLK); #1 bus.ClrErr = 1'b0;
        chk("ovr_clear", 32'(bus.Overrun), 32'h0);

        // Good word arriving with Valid && Ready loads without overrun
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("load_ready", 32'({bus.Overrun, bus.Valid, bus.Data}), 32'h122);

        // Overrun set and ClrErr in the same cycle: set wins
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("ovr_setwins", 32'({bus.Overrun, bus.Valid, bus.Data}), 32'h322);

        // Asynchronous reset mid-frame
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        #2 RST = 1'b1;
        #1;
        chk("async_rst", 32'({bus.Overrun, bus.Valid, bus.FrameErr, bus.ParErr, bus.Data}), 32'h0);
        @(posedge CLK); #1 RST = 1'b0;
        idle(1);
        send_frame(8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst", 32'({bus.Valid, bus.Data}), 32'h180);
        accept();

`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("par_good", 32'({bus.ParErr, bus.Valid, bus.Data}), 32'h1A5);
        accept();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("par_bad", 32'({bus.ParErr, bus.FrameErr, bus.Valid}), 32'h4);
        idle(1);
        chk("par_oneshot", 32'(bus.ParErr), 32'h0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("par_ferr_prec", 32'({bus.ParErr, bus.FrameErr, bus.Valid}), 32'h2);
`endif

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
